// File: rtl/updown_pkg.sv
// Shared definitions for the parametrised up/down counter: direction encodings
// and the default top count for a given width.
package updown_pkg;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  function automatic int default_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/updown_next.sv
// Combinational next-count and boundary detection for updown_counter_mod.
// SATURATE selects hold-at-boundary instead of wrap-around.
module updown_next
  import updown_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX      = 255,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_count_o,
  output logic             boundary_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // An out-of-range count is pulled back to the natural start of the
  // direction of travel; it is not treated as a boundary step.
  always_comb begin
    next_count_o = count_i;
    boundary_o   = 1'b0;
    if (mode_i == MODE_UP) begin
      if (count_i == MAX_VAL) begin
        boundary_o   = 1'b1;
        next_count_o = SATURATE ? MAX_VAL : '0;
      end else if (count_i > MAX_VAL) begin
        next_count_o = '0;
      end else begin
        next_count_o = count_i + ONE;
      end
    end else begin
      if (count_i == '0) begin
        boundary_o   = 1'b1;
        next_count_o = SATURATE ? '0 : MAX_VAL;
      end else if (count_i > MAX_VAL) begin
        next_count_o = MAX_VAL;
      end else begin
        next_count_o = count_i - ONE;
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, preset, clamped load and a registered
// terminal-count pulse. Define UPDOWN_COUNTER_SATURATE_EN to saturate instead of wrap.
module updown_counter_mod
  import updown_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX   = default_max(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] step_count;
  logic             step_boundary;

  updown_next #(
    .WIDTH    (WIDTH),
    .MAX      (MAX),
    .SATURATE (SATURATE)
  ) u_next (
    .count_i      (count_q),
    .mode_i       (mode),
    .next_count_o (step_count),
    .boundary_o   (step_boundary)
  );

  // Preset beats load beats counting; tc is only ever set by an enabled boundary step.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (preset) begin
      count_d = MAX_VAL;
    end else if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (enable) begin
      count_d = step_count;
      tc_d    = step_boundary;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign at_max  = (count_q == MAX_VAL);
  assign at_zero = (count_q == '0);

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised synchronous up/down counter with a programmable modulus, parallel load, preset, count enable and a registered terminal-count pulse. It generalises the team's fixed 5-bit up/down counter for timer, divider and address-sequencing uses. It sits between control logic (which drives `mode`, `enable` and `load`) and consumers of `count` and `tc`. Count values wrap at the modulus by default and saturate when the saturation build option is compiled in.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits; must be at least 2.
- `MAX`, 2**WIDTH-1: top count value; the modulus is MAX+1; must satisfy 1 <= MAX <= 2**WIDTH-1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `preset`  in  1  synchronous preset: forces `count` to MAX.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  value loaded when `load` is high.
- `enable`  in  1  count enable.
- `mode`  in  1  direction: 1 counts up, 0 counts down.
- `count`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal-count pulse, registered.
- `at_max`  out  1  combinational, high when `count` == MAX.
- `at_zero`  out  1  combinational, high when `count` == 0.

## Operation
- While `reset` is high, `count` = 0 and `tc` = 0 immediately, independent of `clk`. `at_zero` = 1 and `at_max` = 0 in this state.
- On each rising edge with `reset` low, the first matching rule applies:
  1. `preset`: `count` <= MAX; `tc` <= 0.
  2. `load`: `count` <= min(`load_val`, MAX); `tc` <= 0.
  3. `enable` && `mode`=1: if `count` == MAX, the counter is at its boundary; otherwise `count` <= `count`+1.
  4. `enable` && `mode`=0: if `count` == 0, the counter is at its boundary; otherwise `count` <= `count`-1.
  5. Otherwise `count` holds and `tc` <= 0.
- Boundary step with the default build: up from MAX gives 0, down from 0 gives MAX, and `tc` <= 1.
- `tc` is high for exactly one cycle per boundary step. With `enable` held high at the boundary, `tc` pulses once per wrap.
- If `count` exceeds MAX, the next enabled step loads 0 (up) or MAX (down). This state is unreachable after reset.
- `mode` may change on any cycle and takes effect on the next enabled edge. There is no direction-change penalty.
- Arithmetic is done in WIDTH bits. No intermediate value exceeds 2**WIDTH-1.

## Timing
- `count` and `tc` update one cycle after the qualifying inputs are sampled.
- `tc` appears in the same cycle that `count` shows the post-wrap value (0 for up, MAX for down).
- `at_max` and `at_zero` follow `count` combinationally, with zero added latency.
- Reset deassertion: the first edge with `reset` low already applies the priority rules.
- Reset asserted mid-count: outputs clear within the reset propagation delay. No pending `tc` survives reset.

## Configuration
- Macro: `UPDOWN_COUNTER_SATURATE_EN`.
- Undefined (default): wrap behaviour as described in Operation.
- Defined: a boundary step holds `count` at its value (MAX going up, 0 going down) and still sets `tc` <= 1 for that cycle.
  - With `enable` held at the boundary, `tc` stays high every cycle.
  - Preset, load and reset behaviour are unchanged.

## Structure
- Shared package `updown_pkg`:
  - `MODE_UP` = 1'b1 and `MODE_DOWN` = 1'b0.
  - A function returning the default MAX for a given WIDTH.
- Sub-module `updown_next` (combinational).
  - Inputs: `count`, `mode`, MAX, and the saturate option.
  - Outputs: the next count and the boundary flag.
- The top level holds the registers and the priority logic.

## Test plan
All scenarios use WIDTH=4, MAX=9.
- Reset and hold: pulse `reset` asynchronously mid-cycle while counting up at 5 -> `count`=0 and `tc`=0 immediately; `at_zero`=1.
- Up wrap: from 0, hold `enable`=1, `mode`=1 for 12 cycles -> 1..9, 0, 1, 2; `tc`=1 only in the cycle `count`=0 after 9.
- Down wrap: load 2, then `mode`=0 for 4 enabled cycles -> 1, 0, 9, 8; `tc`=1 with `count`=9.
- Priority: `preset`=1, `load`=1 (`load_val`=3) and `enable`=1 all in the same cycle -> `count`=9. Next, `load`=1 with `load_val`=14 -> `count`=9 (clamped).
- Direction flip and enable gap: at 4, alternate `mode` every cycle with `enable` toggling -> `count` changes only on enabled edges, in the direction sampled at that edge.
- Saturation (`UPDOWN_COUNTER_SATURATE_EN` defined): count up from 8 for 3 cycles -> 9, 9, 9 with `tc`=0, 1, 1; count down from 1 -> 0, 0 with `tc`=0, 1.
